// File: rtl/jtmx5k_pcmrom_arb.sv
// ---------------------------------------------------------------------------
// jtmx5k_pcmrom_arb
// Time-shares one PCM ROM port between the two 007232 sample channels (A, B),
// the way the original chip shared a single bus. Each channel keeps a
// one-entry cache (valid, tag, data). A channel whose address matches its
// cache is answered combinationally; a miss is queued for a ROM fetch.
//
// Requester handshake (both channels): the requester raises pcmx_cs with
// pcmx_addr and keeps it up until pcmx_ok; pcmx_ok is high exactly when
// pcmx_cs is high and the cache holds pcmx_addr, and pcmx_dout always shows
// the cached byte. ROM handshake: rom_cs/rom_addr are held stable for the
// whole transaction; the first rom_ok after the issue cycle completes it.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   pcma_addr/cs/dout/ok      channel A request / data / data-valid
//   pcmb_addr/cs/dout/ok      channel B request / data / data-valid
//   rom_addr, rom_cs          shared ROM request (registered)
//   rom_data, rom_ok          shared ROM response
//   dbg_state                 current FSM state (IDLE=0, ISSUE=1, WAIT=2)
// ---------------------------------------------------------------------------
module jtmx5k_pcmrom_arb #(
  parameter int AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pcma_addr,
  input  logic          pcma_cs,
  output logic [7:0]    pcma_dout,
  output logic          pcma_ok,
  input  logic [AW-1:0] pcmb_addr,
  input  logic          pcmb_cs,
  output logic [7:0]    pcmb_dout,
  output logic          pcmb_ok,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [7:0]    rom_data,
  input  logic          rom_ok,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t        state;
  logic          gsel;      // channel owning the current transaction (0=A, 1=B)
  logic          last;      // channel served by the last completed fill

  logic          valid_a, valid_b;
  logic [AW-1:0] tag_a, tag_b;
  logic [7:0]    data_a, data_b;

  logic          hit_a, hit_b;
  logic          pend_a, pend_b;
  logic          grant_b;

  assign hit_a  = valid_a && (tag_a == pcma_addr);
  assign hit_b  = valid_b && (tag_b == pcmb_addr);
  assign pend_a = pcma_cs && !hit_a;
  assign pend_b = pcmb_cs && !hit_b;

  assign pcma_ok   = pcma_cs && hit_a;
  assign pcmb_ok   = pcmb_cs && hit_b;
  assign pcma_dout = data_a;
  assign pcmb_dout = data_b;
  assign dbg_state = state;

  // B wins when it is the only one waiting, or on a tie when A went last.
  assign grant_b = pend_b && (!pend_a || !last);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
      valid_a  <= 1'b0;
      valid_b  <= 1'b0;
      tag_a    <= '0;
      tag_b    <= '0;
      data_a   <= 8'd0;
      data_b   <= 8'd0;
      last     <= 1'b1;     // "B went last" so A wins the first tie
      gsel     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pend_a || pend_b) begin
            gsel     <= grant_b;
            rom_addr <= grant_b ? pcmb_addr : pcma_addr;
            rom_cs   <= 1'b1;
            state    <= ISSUE;
          end
        end
        // rom_ok seen here still belongs to the previous address.
        ISSUE: state <= WAIT;
        WAIT: begin
          if (rom_ok) begin
            // Tag comes from the latched address: the requester may have
            // moved on, in which case its new address simply misses again.
            if (gsel) begin
              valid_b <= 1'b1;
              tag_b   <= rom_addr;
              data_b  <= rom_data;
            end else begin
              valid_a <= 1'b1;
              tag_a   <= rom_addr;
              data_a  <= rom_data;
            end
            last   <= gsel;
            rom_cs <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          rom_cs <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtmx5k_pcmrom_arb.sv
// ---------------------------------------------------------------------------
// Testbench for jtmx5k_pcmrom_arb: directed scenarios followed by a random
// phase scored against a simple behavioural model (ROM contents as a function
// of address, one remembered address per channel, expected fetch queues).
// ---------------------------------------------------------------------------
module tb_jtmx5k_pcmrom_arb;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pcma_addr, pcmb_addr;
  logic          pcma_cs, pcmb_cs;
  logic [7:0]    pcma_dout, pcmb_dout;
  logic          pcma_ok, pcmb_ok;
  logic [AW-1:0] rom_addr;
  logic          rom_cs;
  logic [7:0]    rom_data;
  logic          rom_ok;
  logic [1:0]    dbg_state;

  logic          force_en;
  logic [7:0]    force_data;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  jtmx5k_pcmrom_arb #(.AW(AW)) dut (
    .clk(clk), .rst(rst),
    .pcma_addr(pcma_addr), .pcma_cs(pcma_cs), .pcma_dout(pcma_dout), .pcma_ok(pcma_ok),
    .pcmb_addr(pcmb_addr), .pcmb_cs(pcmb_cs), .pcmb_dout(pcmb_dout), .pcmb_ok(pcmb_ok),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .dbg_state(dbg_state)
  );

  // ---------------- ROM model ----------------
  function automatic logic [7:0] rom_fn(input logic [AW-1:0] a);
    logic [31:0] t;
    t = (32'(a) * 32'd37) ^ (32'(a) >> 9) ^ 32'h5C;
    return t[7:0];
  endfunction

  assign rom_data = force_en ? force_data : rom_fn(rom_addr);

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pcma_cs = 1'b0;
    pcmb_cs = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((rom_cs || dbg_state != 2'd0) && n < 40) begin
      tick();
      n++;
    end
    check(tag, 32'(rom_cs), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    logic [AW-1:0] aa, bb;
    logic          oka, okb, prev_cs;
    logic          chan[8];
    int            gap[8];
    int            ntx, idle_run;
    // random-phase model state
    logic [AW-1:0] exp_qa[$];
    logic [AW-1:0] exp_qb[$];
    logic [AW-1:0] e;
    logic          busy_a, busy_b, eh_a, eh_b, have_a, have_b, draining;
    logic [AW-1:0] last_a, last_b;
    int            age_a, age_b;

    rst = 1'b1;
    pcma_cs = 1'b0; pcmb_cs = 1'b0;
    pcma_addr = '0; pcmb_addr = '0;
    rom_ok = 1'b0; force_en = 1'b0; force_data = 8'h00;

    // ---- reset state ----
    tick();
    @(negedge clk);
    check("rst_rom_cs", 32'(rom_cs), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    check("rst_douts", {16'd0, pcma_dout, pcmb_dout}, 32'd0);
    pcma_cs = 1'b1; pcmb_cs = 1'b1;   // requests during reset must not hit
    #1;
    check("rst_oks", {30'd0, pcma_ok, pcmb_ok}, 32'd0);
    tick();
    do_reset();

    // ---- single miss, fast ROM ----
    pcma_cs = 1'b1; pcma_addr = 17'h00123;
    rom_ok = 1'b1; force_en = 1'b1; force_data = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("miss_cs_k%0d", k), 32'(rom_cs), 32'(k == 1 || k == 2));
      if (k == 1 || k == 2) check($sformatf("miss_addr_k%0d", k), 32'(rom_addr), 32'h00123);
      check($sformatf("miss_ok_k%0d", k), 32'(pcma_ok), 32'(k >= 3));
      if (k >= 3) check($sformatf("miss_dout_k%0d", k), 32'(pcma_dout), 32'h5A);
      tick();
    end
    pcma_cs = 1'b0; force_en = 1'b0;

    // ---- tie after reset: A first, one idle cycle, then B ----
    do_reset();
    pcma_cs = 1'b1; pcma_addr = 17'h00010;
    pcmb_cs = 1'b1; pcmb_addr = 17'h10020;
    rom_ok = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      check($sformatf("tie_cs_k%0d", k), 32'(rom_cs), 32'(k == 1 || k == 2 || k == 4 || k == 5));
      if (k == 1) check("tie_addr_first", 32'(rom_addr), 32'h00010);
      if (k == 4) check("tie_addr_second", 32'(rom_addr), 32'h10020);
      if (k == 3) begin
        check("tie_a_ok", 32'(pcma_ok), 32'd1);
        check("tie_a_dout", 32'(pcma_dout), 32'(rom_fn(17'h00010)));
        check("tie_b_not_ok", 32'(pcmb_ok), 32'd0);
      end
      if (k == 6) begin
        check("tie_b_ok", 32'(pcmb_ok), 32'd1);
        check("tie_b_dout", 32'(pcmb_dout), 32'(rom_fn(17'h10020)));
      end
      tick();
    end

    // ---- round robin with both channels stepping ----
    aa = 17'h00300; bb = 17'h12300;
    pcma_addr = aa; pcmb_addr = bb;
    ntx = 0; idle_run = 0; prev_cs = rom_cs;
    for (int c = 0; c < 80 && ntx < 8; c++) begin
      @(negedge clk);
      oka = pcma_ok; okb = pcmb_ok;
      if (rom_cs && !prev_cs) begin
        chan[ntx] = rom_addr[16];
        gap[ntx] = idle_run;
        idle_run = 0;
        ntx++;
      end else if (!rom_cs) begin
        idle_run++;
      end
      prev_cs = rom_cs;
      tick();
      if (oka) begin aa = aa + 17'd1; pcma_addr = aa; end
      if (okb) begin bb = bb + 17'd1; pcmb_addr = bb; end
    end
    check("rr_count", 32'(ntx), 32'd8);
    for (int i = 0; i < ntx; i++) begin
      check($sformatf("rr_chan_%0d", i), 32'(chan[i]), 32'(i % 2));
      if (i > 0) check($sformatf("rr_gap_%0d", i), 32'(gap[i]), 32'd1);
    end
    pcma_cs = 1'b0; pcmb_cs = 1'b0;
    wait_idle("rr_drain");

    // ---- slow ROM with stale ok during ISSUE (channel B) ----
    pcmb_cs = 1'b1; pcmb_addr = 17'h1F000;
    rom_ok = 1'b1; force_en = 1'b1; force_data = 8'h11;
    for (int k = 0; k < 9; k++) begin
      if (k >= 2 && k <= 6) rom_ok = 1'b0;
      if (k == 7) begin rom_ok = 1'b1; force_data = 8'hC3; end
      @(negedge clk);
      check($sformatf("slow_cs_k%0d", k), 32'(rom_cs), 32'(k >= 1 && k <= 7));
      check($sformatf("slow_ok_k%0d", k), 32'(pcmb_ok), 32'(k == 8));
      if (k == 8) check("slow_dout", 32'(pcmb_dout), 32'hC3);
      tick();
    end
    pcmb_cs = 1'b0; force_en = 1'b0;

    // ---- address change during WAIT (channel A) ----
    pcma_cs = 1'b1; pcma_addr = 17'h00200;
    rom_ok = 1'b0; force_en = 1'b1; force_data = 8'h77;
    for (int k = 0; k < 9; k++) begin
      if (k == 3) pcma_addr = 17'h00201;
      if (k == 4) rom_ok = 1'b1;
      if (k == 5) rom_ok = 1'b0;
      if (k == 6) begin rom_ok = 1'b1; force_data = 8'h88; end
      @(negedge clk);
      if (k == 2) check("chg_addr_latched", 32'(rom_addr), 32'h00200);
      if (k == 5) begin
        check("chg_ok_low", 32'(pcma_ok), 32'd0);
        check("chg_old_data", 32'(pcma_dout), 32'h77);
        check("chg_idle_gap", 32'(rom_cs), 32'd0);
      end
      if (k == 6) begin
        check("chg_reissue_cs", 32'(rom_cs), 32'd1);
        check("chg_reissue_addr", 32'(rom_addr), 32'h00201);
      end
      if (k == 8) begin
        check("chg_final_ok", 32'(pcma_ok), 32'd1);
        check("chg_final_dout", 32'(pcma_dout), 32'h88);
      end
      tick();
    end
    pcma_cs = 1'b0;

    // ---- reset mid-WAIT ----
    pcma_cs = 1'b1; pcma_addr = 17'h00400;
    rom_ok = 1'b0; force_data = 8'h99;
    for (int k = 0; k < 8; k++) begin
      if (k == 3) begin rst = 1'b1; rom_ok = 1'b1; end
      if (k == 4) begin rst = 1'b0; rom_ok = 1'b0; end
      if (k == 5) rom_ok = 1'b1;
      @(negedge clk);
      if (k == 4) begin
        check("rstw_cs", 32'(rom_cs), 32'd0);
        check("rstw_oks", {30'd0, pcma_ok, pcmb_ok}, 32'd0);
        check("rstw_dout_discard", 32'(pcma_dout), 32'd0);
      end
      if (k == 5) begin
        check("rstw_reissue_cs", 32'(rom_cs), 32'd1);
        check("rstw_reissue_addr", 32'(rom_addr), 32'h00400);
      end
      if (k == 7) begin
        check("rstw_ok", 32'(pcma_ok), 32'd1);
        check("rstw_dout", 32'(pcma_dout), 32'h99);
      end
      tick();
    end
    pcma_cs = 1'b0; force_en = 1'b0;

    // ---- random phase against the behavioural model ----
    do_reset();
    busy_a = 1'b0; busy_b = 1'b0; have_a = 1'b0; have_b = 1'b0;
    eh_a = 1'b0; eh_b = 1'b0; age_a = 0; age_b = 0;
    last_a = '0; last_b = '0; prev_cs = 1'b0; draining = 1'b0;
    for (int cyc = 0; cyc < 1800; cyc++) begin
      draining = (cyc >= 1500);
      if (draining && !busy_a && !busy_b && !rom_cs) break;
      @(negedge clk);
      // every fetch must be one the model expects, in request order per channel
      if (rom_cs && !prev_cs) begin
        if (!rom_addr[16]) begin
          e = (exp_qa.size() != 0) ? exp_qa.pop_front() : '1;
          check("rnd_fetch_a", 32'(rom_addr), 32'(e));
        end else begin
          e = (exp_qb.size() != 0) ? exp_qb.pop_front() : '1;
          check("rnd_fetch_b", 32'(rom_addr), 32'(e));
        end
      end
      prev_cs = rom_cs;
      if (busy_a) begin
        if (pcma_ok) begin
          check("rnd_dout_a", 32'(pcma_dout), 32'(rom_fn(pcma_addr)));
          check("rnd_hit_now_a", 32'(age_a == 0), 32'(eh_a));
          busy_a = 1'b0; have_a = 1'b1; last_a = pcma_addr;
        end else begin
          age_a++;
          if (age_a > 60) begin check("rnd_timeout_a", 32'(age_a), 32'd60); busy_a = 1'b0; end
        end
      end
      if (busy_b) begin
        if (pcmb_ok) begin
          check("rnd_dout_b", 32'(pcmb_dout), 32'(rom_fn(pcmb_addr)));
          check("rnd_hit_now_b", 32'(age_b == 0), 32'(eh_b));
          busy_b = 1'b0; have_b = 1'b1; last_b = pcmb_addr;
        end else begin
          age_b++;
          if (age_b > 60) begin check("rnd_timeout_b", 32'(age_b), 32'd60); busy_b = 1'b0; end
        end
      end
      tick();
      rom_ok = ($urandom_range(0, 3) != 0);
      if (!busy_a) begin
        if (draining || $urandom_range(0, 2) == 0) pcma_cs = 1'b0;
        else begin
          pcma_addr = 17'h00100 + 17'($urandom_range(0, 5));
          pcma_cs = 1'b1; busy_a = 1'b1; age_a = 0;
          eh_a = have_a && (last_a == pcma_addr);
          if (!eh_a) exp_qa.push_back(pcma_addr);
        end
      end
      if (!busy_b) begin
        if (draining || $urandom_range(0, 2) == 0) pcmb_cs = 1'b0;
        else begin
          pcmb_addr = 17'h1A000 + 17'($urandom_range(0, 5));
          pcmb_cs = 1'b1; busy_b = 1'b1; age_b = 0;
          eh_b = have_b && (last_b == pcmb_addr);
          if (!eh_b) exp_qb.push_back(pcmb_addr);
        end
      end
    end
    check("rnd_qa_empty", 32'(exp_qa.size()), 32'd0);
    check("rnd_qb_empty", 32'(exp_qb.size()), 32'd0);
    check("rnd_busy_done", {30'd0, busy_a, busy_b}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
